// File: rtl/ecc_pkg.sv
// Shared constants for the extended-Hamming (SECDED) encoder: code widths, mode encoding
// and the H-matrix rows of each supported code.
package ecc_pkg;

    localparam int CODE_W       = 32;

    localparam int INFO_W_8_4   = 4;
    localparam int INFO_W_16_11 = 11;
    localparam int INFO_W_32_26 = 26;

    localparam int PAR_W_8_4    = 4;
    localparam int PAR_W_16_11  = 5;
    localparam int PAR_W_32_26  = 6;

    typedef enum logic [1:0] {
        MODE_8_4     = 2'b00,
        MODE_16_11   = 2'b01,
        MODE_32_26   = 2'b10,
        MODE_ILLEGAL = 2'b11
    } mode_e;

    // Element r-1 holds H row r; bit j of a row is the column of info bit j. The columns
    // are all weight>=2 values in ascending order, so every row has odd weight.
    localparam logic [CODE_W-1:0] H_8_4 [PAR_W_8_4-1] = '{
        32'h0000000E,
        32'h0000000D,
        32'h0000000B
    };

    localparam logic [CODE_W-1:0] H_16_11 [PAR_W_16_11-1] = '{
        32'h000007F0,
        32'h0000078E,
        32'h0000066D,
        32'h0000055B
    };

    localparam logic [CODE_W-1:0] H_32_26 [PAR_W_32_26-1] = '{
        32'h03FFF800,
        32'h03FC07F0,
        32'h03C3C78E,
        32'h0333366D,
        32'h02AAAD5B
    };

    function automatic logic isIllegal(input mode_e mode);
        return (mode == MODE_ILLEGAL);
    endfunction

endpackage

// File: rtl/parity_gen.sv
// Combinational Hamming parity generator: places the info word and its Hamming parity
// bits into the codeword layout, leaving the overall-parity slot at zero.
module parity_gen
    import ecc_pkg::*;
#(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int MAX_INFO_WIDTH     = 26
) (
    input  logic [MAX_INFO_WIDTH-1:0]     info_i,
    input  mode_e                         mode_i,
    output logic [MAX_CODEWORD_WIDTH-1:0] codeword_o
);

    always_comb begin
        codeword_o = '0;
        case (mode_i)
            MODE_8_4: begin
                codeword_o[INFO_W_8_4+PAR_W_8_4-1:PAR_W_8_4] = info_i[INFO_W_8_4-1:0];
                for (int r = 0; r < PAR_W_8_4 - 1; r++) begin
                    codeword_o[PAR_W_8_4-2-r] =
                        ^(H_8_4[r][INFO_W_8_4-1:0] & info_i[INFO_W_8_4-1:0]);
                end
            end
            MODE_16_11: begin
                codeword_o[INFO_W_16_11+PAR_W_16_11-1:PAR_W_16_11] = info_i[INFO_W_16_11-1:0];
                for (int r = 0; r < PAR_W_16_11 - 1; r++) begin
                    codeword_o[PAR_W_16_11-2-r] =
                        ^(H_16_11[r][INFO_W_16_11-1:0] & info_i[INFO_W_16_11-1:0]);
                end
            end
            MODE_32_26: begin
                codeword_o[INFO_W_32_26+PAR_W_32_26-1:PAR_W_32_26] = info_i[INFO_W_32_26-1:0];
                for (int r = 0; r < PAR_W_32_26 - 1; r++) begin
                    codeword_o[PAR_W_32_26-2-r] =
                        ^(H_32_26[r][INFO_W_32_26-1:0] & info_i[INFO_W_32_26-1:0]);
                end
            end
            default: codeword_o = '0;
        endcase
    end

endmodule

// File: rtl/enc_pipe.sv
// Two-stage elastic SECDED encoder: stage 1 builds the Hamming codeword, stage 2 inserts
// the overall-parity bit and drives the output handshake.
module enc_pipe
    import ecc_pkg::*;
#(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int MAX_INFO_WIDTH     = 26
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MAX_INFO_WIDTH-1:0]     data_in,
    input  logic [1:0]                    work_mod,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
    output logic                          mode_err
);

    logic                          s1ValidQ;
    logic [MAX_CODEWORD_WIDTH-1:0] s1CodeQ;
    logic [MAX_CODEWORD_WIDTH-1:0] s1CodeD;
    mode_e                         s1ModeQ;
    mode_e                         s1ModeD;
    logic                          s1ErrQ;

    logic                          s2ValidQ;
    logic [MAX_CODEWORD_WIDTH-1:0] s2DataQ;
    logic [MAX_CODEWORD_WIDTH-1:0] s2DataD;
    logic                          s2ErrQ;

    logic                          s1Load;
    logic                          s2Load;

    // Ready depends only on stage occupancy and out_ready, never on in_valid.
    assign s2Load   = !s2ValidQ || out_ready;
    assign s1Load   = !s1ValidQ || s2Load;
    assign in_ready = s1Load;

    assign s1ModeD  = mode_e'(work_mod);

    parity_gen #(
        .MAX_CODEWORD_WIDTH(MAX_CODEWORD_WIDTH),
        .MAX_INFO_WIDTH    (MAX_INFO_WIDTH)
    ) u_parity_gen (
        .info_i    (data_in),
        .mode_i    (s1ModeD),
        .codeword_o(s1CodeD)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1ValidQ <= 1'b0;
            s1CodeQ  <= '0;
            s1ModeQ  <= MODE_8_4;
            s1ErrQ   <= 1'b0;
        end else if (s1Load) begin
            s1ValidQ <= in_valid;
            if (in_valid) begin
                s1CodeQ <= s1CodeD;
                s1ModeQ <= s1ModeD;
                s1ErrQ  <= isIllegal(s1ModeD);
            end
        end
    end

    // The parity slot is still zero, so reducing the whole word yields the overall parity.
    always_comb begin
        s2DataD = s1CodeQ;
        case (s1ModeQ)
            MODE_8_4:   s2DataD[PAR_W_8_4-1]   = ^s1CodeQ;
            MODE_16_11: s2DataD[PAR_W_16_11-1] = ^s1CodeQ;
            MODE_32_26: s2DataD[PAR_W_32_26-1] = ^s1CodeQ;
            default:    s2DataD = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2ValidQ <= 1'b0;
            s2DataQ  <= '0;
            s2ErrQ   <= 1'b0;
        end else if (s2Load) begin
            s2ValidQ <= s1ValidQ;
            if (s1ValidQ) begin
                s2DataQ <= s2DataD;
                s2ErrQ  <= s1ErrQ;
            end
        end
    end

    assign out_valid = s2ValidQ;
    assign data_out  = s2DataQ;
    assign mode_err  = s2ErrQ;

endmodule

// File: tb/tb_enc_pipe.sv
// Directed bench for enc_pipe: hand-computed codewords pushed to an expected queue at
// capture time and compared in order as words leave the pipeline.
module tb_enc_pipe;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [25:0] data_in   = '0;
    logic [1:0]  work_mod  = '0;
    logic        in_ready;
    logic        out_valid;
    logic        mode_err;
    logic [31:0] data_out;

    typedef struct packed {
        logic [25:0] data;
        logic [1:0]  mode;
        logic [31:0] expData;
        logic        expErr;
    } vec_t;

    vec_t vecs [17];
    vec_t expQ [$];
    vec_t expWord;

    int testCount = 0;
    int failCount = 0;
    int outCount  = 0;
    int acc;
    int cyc;

    enc_pipe #(
        .MAX_CODEWORD_WIDTH(32),
        .MAX_INFO_WIDTH    (26)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data_in  (data_in),
        .work_mod (work_mod),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out (data_out),
        .mode_err (mode_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Presents words first..first+count-1; called and returns just after a rising edge.
    task automatic applyStimulus(input int first, input int count, input int maxCycles,
                                 output int accepted, output int cycles);
        logic take;
        accepted = 0;
        cycles   = 0;
        while (accepted < count && cycles < maxCycles) begin
            in_valid = 1'b1;
            data_in  = vecs[first+accepted].data;
            work_mod = vecs[first+accepted].mode;
            @(negedge clk);
            take = in_ready;
            @(posedge clk);
            cycles++;
            if (take) begin
                expQ.push_back(vecs[first+accepted]);
                accepted++;
            end
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedWord", data_out, 32'hDEADBEEF);
            end else begin
                expWord = expQ.pop_front();
                checkOutput("outData", data_out, expWord.expData);
                checkOutput("outErr", {31'b0, mode_err}, {31'b0, expWord.expErr});
            end
            outCount++;
        end
    end

    initial begin
        vecs[0]  = '{26'h000000B, 2'b00, 32'h000000B1, 1'b0};
        vecs[1]  = '{26'h0000001, 2'b01, 32'h00000033, 1'b0};
        vecs[2]  = '{26'h00007FF, 2'b01, 32'h0000FFFF, 1'b0};
        vecs[3]  = '{26'h3FFFFFF, 2'b10, 32'hFFFFFFFF, 1'b0};
        vecs[4]  = '{26'h000000F, 2'b00, 32'h000000FF, 1'b0};
        vecs[5]  = '{26'h3FFFFF0, 2'b00, 32'h00000000, 1'b0};
        vecs[6]  = '{26'h0000001, 2'b10, 32'h00000063, 1'b0};
        vecs[7]  = '{26'h0000400, 2'b01, 32'h0000801F, 1'b0};
        vecs[8]  = '{26'h000000B, 2'b00, 32'h000000B1, 1'b0};
        vecs[9]  = '{26'h3FFFFFF, 2'b10, 32'hFFFFFFFF, 1'b0};
        vecs[10] = '{26'h0000155, 2'b11, 32'h00000000, 1'b1};
        vecs[11] = '{26'h0000001, 2'b01, 32'h00000033, 1'b0};
        vecs[12] = '{26'h00007FF, 2'b01, 32'h0000FFFF, 1'b0};
        vecs[13] = '{26'h000000F, 2'b00, 32'h000000FF, 1'b0};
        vecs[14] = '{26'h0000001, 2'b10, 32'h00000063, 1'b0};
        vecs[15] = '{26'h000000B, 2'b00, 32'h000000B1, 1'b0};
        vecs[16] = '{26'h00007FF, 2'b01, 32'h0000FFFF, 1'b0};

        out_ready = 1'b1;
        #12;
        checkOutput("rstInReady", {31'b0, in_ready}, 32'd1);
        checkOutput("rstOutValid", {31'b0, out_valid}, 32'd0);
        checkOutput("rstDataOut", data_out, 32'd0);
        checkOutput("rstModeErr", {31'b0, mode_err}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        idleCycles(1);

        // Word driven after edge N is visible after edge N+2.
        applyStimulus(0, 1, 4, acc, cyc);
        checkOutput("lat0Accepted", acc, 32'd1);
        checkOutput("latEdge1Valid", {31'b0, out_valid}, 32'd0);
        idleCycles(1);
        checkOutput("latEdge2Valid", {31'b0, out_valid}, 32'd1);
        checkOutput("latEdge2Data", data_out, 32'h000000B1);
        idleCycles(3);

        applyStimulus(1, 7, 20, acc, cyc);
        checkOutput("singlesAccepted", acc, 32'd7);
        checkOutput("singlesCycles", cyc, 32'd7);
        idleCycles(4);
        checkOutput("singlesOutCount", outCount, 32'd8);

        applyStimulus(8, 4, 10, acc, cyc);
        checkOutput("mixedAccepted", acc, 32'd4);
        checkOutput("mixedCycles", cyc, 32'd4);
        idleCycles(4);
        checkOutput("mixedOutCount", outCount, 32'd12);
        checkOutput("mixedQueueEmpty", expQ.size(), 32'd0);

        out_ready = 1'b0;
        applyStimulus(12, 3, 5, acc, cyc);
        checkOutput("bpAccepted", acc, 32'd2);
        checkOutput("bpInReady", {31'b0, in_ready}, 32'd0);
        checkOutput("bpOutValid", {31'b0, out_valid}, 32'd1);
        checkOutput("bpHoldData", data_out, 32'h0000FFFF);
        idleCycles(2);
        checkOutput("bpStableData", data_out, 32'h0000FFFF);
        checkOutput("bpStableErr", {31'b0, mode_err}, 32'd0);
        out_ready = 1'b1;
        #1;
        checkOutput("bpReleaseReady", {31'b0, in_ready}, 32'd1);
        applyStimulus(14, 1, 2, acc, cyc);
        checkOutput("bpReleaseAccepted", acc, 32'd1);
        idleCycles(4);
        checkOutput("bpOutCount", outCount, 32'd15);
        checkOutput("bpQueueEmpty", expQ.size(), 32'd0);

        applyStimulus(15, 2, 4, acc, cyc);
        checkOutput("rstMidAccepted", acc, 32'd2);
        #2 rst = 1'b0;
        #1;
        checkOutput("rstMidOutValid", {31'b0, out_valid}, 32'd0);
        checkOutput("rstMidDataOut", data_out, 32'd0);
        checkOutput("rstMidInReady", {31'b0, in_ready}, 32'd1);
        expQ.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        idleCycles(1);
        checkOutput("postRstOutValid", {31'b0, out_valid}, 32'd0);
        applyStimulus(0, 1, 4, acc, cyc);
        idleCycles(3);
        checkOutput("postRstOutCount", outCount, 32'd16);
        checkOutput("postRstQueueEmpty", expQ.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
